// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  // Requester side (datapath controller / testbench)
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  // Divider side
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, unsigned or
// two's-complement operands, with divide-by-zero and signed-overflow flags.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, q, dvs;
  logic             q_neg, r_neg, ovf_pend;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             dbz_r, ovf_r;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;

  // Magnitude of an operand; only signed operands with the sign bit set are negated.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  assign accept = bus.start && (state == IDLE || state == DONE);

  // One restoring step: shift the next dividend bit into the partial remainder
  // and try to subtract the divisor magnitude.
  assign shifted   = {rem, q[WIDTH-1]};
  assign trial     = {1'b0, shifted} - {2'b00, dvs};
  // A non-negative trial is always below the divisor and so fits in WIDTH bits;
  // any set upper bit therefore means the subtraction borrowed.
  assign trial_neg = trial[WIDTH+1] | trial[WIDTH];

  // State register
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  // NOTE: the default assignment first keeps this purely combinational; a
  // branch that forgot state_next would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (!accept)                state_next = IDLE;
        else if (bus.divisor == '0) state_next = DONE;
        else                        state_next = CALC;
      end
      CALC:    if (count == CW'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and result sign fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem         <= '0;
      q           <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (accept) begin
      count    <= CW'(WIDTH);
      rem      <= '0;
      q        <= mag(bus.dividend, bus.signed_op);
      dvs      <= mag(bus.divisor, bus.signed_op);
      q_neg    <= bus.signed_op && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_neg    <= bus.signed_op && bus.dividend[WIDTH-1];
      ovf_pend <= bus.signed_op && bus.dividend == MIN_VAL && bus.divisor == '1;
      dbz_r    <= 1'b0;
      ovf_r    <= 1'b0;
      // A zero divisor finishes immediately; otherwise the previous results
      // stay visible until the new operation completes.
      if (bus.divisor == '0) begin
        quotient_r  <= '1;
        remainder_r <= bus.dividend;
        dbz_r       <= 1'b1;
      end
    end else if (state == CALC) begin
      count <= count - CW'(1);
      rem   <= trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      q     <= {q[WIDTH-2:0], ~trial_neg};
    end else if (state == FIX) begin
      // MIN / -1 falls out naturally: |MIN|/1 = MIN as an unsigned pattern, no negation.
      quotient_r  <= q_neg ? -q : q;
      remainder_r <= r_neg ? -rem : rem;
      ovf_r       <= ovf_pend;
    end
  end

  assign bus.busy        = (state == CALC) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider at WIDTH=8.
module tb_seq_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miscmp = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, dividend-signed remainder, special cases.
  task automatic ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output bit dz, output bit ov);
    int sa, sb;
    dz = 0; ov = 0;
    if (b == 0) begin
      q = '1; r = a; dz = 1;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -(1 << (W-1)) && sb == -1) begin
        q = a; r = '0; ov = 1;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
    end
  endtask

  // Present a request and let the next rising edge accept it; returns in the
  // cycle after the accepting edge.
  task automatic launch(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.signed_op = s; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Count cycles (1 = cycle after acceptance) until done, bounded.
  task automatic wait_done(input bit glitch, output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (glitch && k == 3) begin
        bus.start = 1'b1; bus.dividend = 8'h11; bus.divisor = 8'h01;
        bus.signed_op = ~bus.signed_op;
      end else if (glitch && k == 4) begin
        bus.start = 1'b0;
      end
      if (bus.busy) nbusy++;
      if (bus.done) begin lat = k; break; end
    end
  endtask

  task automatic op(input string tag, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz, input bit eov,
                    input bit glitch = 0, input int hold_q = -1);
    int lat, nbusy;
    launch(s, a, b);
    if (hold_q >= 0) check({tag, "_held_q"}, bus.quotient, hold_q);
    wait_done(glitch, lat, nbusy);
    check({tag, "_lat"},  lat,   edz ? 1 : W + 2);
    check({tag, "_busy"}, nbusy, edz ? 0 : W + 1);
    check({tag, "_q"},    bus.quotient, eq);
    check({tag, "_r"},    bus.remainder, er);
    check({tag, "_dz"},   bus.div_by_zero, edz);
    check({tag, "_ov"},   bus.overflow, eov);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    bit rs, rdz, rov;

    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;

    // Reset state
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    check("rst_flags", {bus.div_by_zero, bus.overflow}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic unsigned and signed vectors
    op("u200_7", 0, 8'd200, 8'd7, 8'd28, 8'd4, 0, 0);
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    op("s_m7_2", 1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 0);
    op("s_7_m2", 1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 0);
    op("s_m127_127", 1, 8'h81, 8'h7F, 8'hFF, 8'h00, 0, 0);

    // Divide by zero, both modes
    op("u_dz", 0, 8'h0D, 8'h00, 8'hFF, 8'h0D, 1, 0);
    op("s_dz", 1, 8'h0D, 8'h00, 8'hFF, 8'h0D, 1, 0);

    // MIN / -1
    op("s_ovf", 1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1);
    op("u_min", 0, 8'h80, 8'hFF, 8'h00, 8'h80, 0, 0);

    // Ignored mid-CALC start, then back-to-back start in the DONE cycle
    op("glitch", 0, 8'd100, 8'd9, 8'd11, 8'd1, 0, 0, 1);
    op("b2b", 1, 8'hF0, 8'h03, 8'hFB, 8'hFF, 0, 0, 0, 8'd11);

    // Reset mid-operation
    launch(0, 8'd100, 8'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_q", bus.quotient, 0);
    check("mid_rst_r", bus.remainder, 0);
    check("mid_rst_flags", {bus.div_by_zero, bus.overflow}, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) check("post_rst_quiet", {bus.done, bus.busy}, 0);
    end
    op("u255_16", 0, 8'd255, 8'd16, 8'd15, 8'd15, 0, 0);

    // Random operand pairs against the reference model
    for (int i = 0; i < 1500; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 50 == 0) rb = '0;
      if (i % 50 == 1) begin ra = 8'h80; rb = 8'hFF; end
      ref_div(rs, ra, rb, rq, rr, rdz, rov);
      op("rand", rs, ra, rb, rq, rr, rdz, rov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
